laser_scan_ctrl: RTL and testbench



---
 rtl/laser_scan_ctrl_pkg.sv | 20 ++
 rtl/laser_scan_ctrl_if.sv | 27 ++
 rtl/laser_scan_coord_gen.sv | 33 +++
 rtl/laser_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_laser_scan_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/laser_scan_ctrl_pkg.sv
// Shared types and defaults for the laser coverage scan controller.
// No logic; latency and backpressure n/a.
package laser_pkg;
    localparam int DEF_COORD_W = 4;
    localparam int DEF_CNT_W   = 6;

    function automatic int grid_last(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int GRID_LAST = grid_last(DEF_COORD_W);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PASS_END,
        DONE
    } state_t;
endpackage

// File: rtl/laser_scan_ctrl_if.sv
// Evaluator bundle: candidate + fixed partner circle out, covered-count strobe back.
// No state; candidate side is valid/ready, result side is a bare strobe.
interface laser_scan_ctrl_if
    import laser_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int CNT_W   = DEF_CNT_W
) ();
    logic               cand_valid;
    logic               cand_ready;
    logic [COORD_W-1:0] cand_x;
    logic [COORD_W-1:0] cand_y;
    logic [COORD_W-1:0] fix_x;
    logic [COORD_W-1:0] fix_y;
    logic               res_valid;
    logic [CNT_W-1:0]   res_count;

    modport master (
        output cand_valid, cand_x, cand_y, fix_x, fix_y,
        input  cand_ready, res_valid, res_count
    );

    modport slave (
        input  cand_valid, cand_x, cand_y, fix_x, fix_y,
        output cand_ready, res_valid, res_count
    );
endinterface

// File: rtl/laser_scan_coord_gen.sv
// Raster counter over the candidate grid, X fastest; last flags (max,max).
// Registered position, advances one step per advance pulse; clear wins over advance.
module laser_scan_coord_gen
    import laser_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);
    localparam logic [COORD_W-1:0] LAST = COORD_W'(grid_last(COORD_W));

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == LAST) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign last = (x == LAST) && (y == LAST);
endmodule

// File: rtl/laser_scan_ctrl.sv
// Two-circle coverage optimiser: scans every centre per pass, keeps the best, alternates target.
// 2 cycles/candidate minimum plus 1 per pass; holds candidate while cand_ready is low.
module laser_scan_ctrl
    import laser_pkg::*;
#(
    parameter int COORD_W  = DEF_COORD_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int MAX_PASS = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    laser_scan_ctrl_if.master  ev,
    output logic               busy,
    output logic               done,
    output logic [COORD_W-1:0] C1X,
    output logic [COORD_W-1:0] C1Y,
    output logic [COORD_W-1:0] C2X,
    output logic [COORD_W-1:0] C2Y
);
    state_t             state, state_n;
    logic [3:0]         pass_cnt;
    logic [1:0]         stable_cnt, stable_n;
    logic [CNT_W-1:0]   best;
    logic [COORD_W-1:0] best_x, best_y, scan_x, scan_y, prev_x, prev_y;
    logic               scan_clr, scan_adv, scan_last, finish;

    laser_scan_coord_gen #(.COORD_W(COORD_W)) u_coord (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (scan_clr),
        .advance (scan_adv),
        .x       (scan_x),
        .y       (scan_y),
        .last    (scan_last)
    );

    // Even passes move circle 1 against circle 2, odd passes the reverse.
    assign prev_x   = pass_cnt[0] ? C2X : C1X;
    assign prev_y   = pass_cnt[0] ? C2Y : C1Y;
    assign stable_n = (best_x == prev_x && best_y == prev_y) ? stable_cnt + 2'd1 : 2'd0;
    assign finish   = (stable_n == 2'd2) || (pass_cnt + 4'd1 == 4'(MAX_PASS));

    assign ev.cand_valid = (state == ISSUE);
    assign ev.cand_x     = scan_x;
    assign ev.cand_y     = scan_y;
    assign ev.fix_x      = pass_cnt[0] ? C1X : C2X;
    assign ev.fix_y      = pass_cnt[0] ? C1Y : C2Y;
    assign busy          = (state == ISSUE) || (state == WAIT) || (state == PASS_END);
    assign done          = (state == DONE);

    always_comb begin
        state_n  = state;
        scan_clr = 1'b0;
        scan_adv = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n  = ISSUE;
                    scan_clr = 1'b1;
                end
            end
            ISSUE: begin
                if (ev.cand_ready) state_n = WAIT;
            end
            WAIT: begin
                if (ev.res_valid) begin
                    if (scan_last) begin
                        state_n = PASS_END;
                    end else begin
                        state_n  = ISSUE;
                        scan_adv = 1'b1;
                    end
                end
            end
            PASS_END: begin
                scan_clr = 1'b1;
                state_n  = finish ? DONE : ISSUE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            pass_cnt   <= '0;
            stable_cnt <= '0;
            best       <= '0;
            best_x     <= '0;
            best_y     <= '0;
            C1X        <= '0;
            C1Y        <= '0;
            C2X        <= '0;
            C2Y        <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pass_cnt   <= '0;
                        stable_cnt <= '0;
                        best       <= '0;
                    end
                end
                WAIT: begin
                    // >= lets the later scan position win a tie.
                    if (ev.res_valid && ev.res_count >= best) begin
                        best   <= ev.res_count;
                        best_x <= scan_x;
                        best_y <= scan_y;
                    end
                end
                PASS_END: begin
                    if (pass_cnt[0]) begin
                        C2X <= best_x;
                        C2Y <= best_y;
                    end else begin
                        C1X <= best_x;
                        C1Y <= best_y;
                    end
                    stable_cnt <= stable_n;
                    pass_cnt   <= pass_cnt + 4'd1;
                    best       <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_laser_scan_ctrl.sv
// Bench for laser_scan_ctrl: behavioural evaluator with random latency/stalls and a pass-level model.
module tb_laser_scan_ctrl;
    import laser_pkg::*;

    localparam int G  = GRID_LAST + 1;
    localparam int NP = 6;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic start = 1'b0;
    logic busy, done;
    logic [3:0] C1X, C1Y, C2X, C2Y;

    laser_scan_ctrl_if #(.COORD_W(4), .CNT_W(6)) ev ();

    laser_scan_ctrl #(.COORD_W(4), .CNT_W(6), .MAX_PASS(NP)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .start (start),
        .ev    (ev.master),
        .busy  (busy),
        .done  (done),
        .C1X   (C1X),
        .C1Y   (C1Y),
        .C2X   (C2X),
        .C2Y   (C2Y)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Score tables per pass, and the pass-level reference results.
    int sc [NP][G*G];
    int mfx [NP];
    int mfy [NP];
    int m_c1x = 0, m_c1y = 0, m_c2x = 0, m_c2y = 0;
    int m_passes = 0;

    task automatic model_run();
        int best, bpos, stable, tx, ty;
        bit same;
        stable   = 0;
        m_passes = 0;
        for (int p = 0; p < NP; p++) begin
            mfx[p] = (p % 2 == 1) ? m_c1x : m_c2x;
            mfy[p] = (p % 2 == 1) ? m_c1y : m_c2y;
            best = 0;
            bpos = 0;
            for (int i = 0; i < G*G; i++)
                if (sc[p][i] >= best) begin
                    best = sc[p][i];
                    bpos = i;
                end
            tx = bpos % G;
            ty = bpos / G;
            if (p % 2 == 0) begin
                same  = (tx == m_c1x) && (ty == m_c1y);
                m_c1x = tx;
                m_c1y = ty;
            end else begin
                same  = (tx == m_c2x) && (ty == m_c2y);
                m_c2x = tx;
                m_c2y = ty;
            end
            stable   = same ? stable + 1 : 0;
            m_passes = p + 1;
            if (stable == 2) break;
        end
    endtask

    task automatic fill_peaks(input int a, input int b, input int val);
        for (int p = 0; p < NP; p++)
            for (int i = 0; i < G*G; i++)
                sc[p][i] = (i == a || i == b) ? val : 0;
    endtask

    task automatic fill_rand();
        for (int p = 0; p < NP; p++)
            for (int i = 0; i < G*G; i++)
                sc[p][i] = int'($urandom_range(0, 40));
    endtask

    // Evaluator model: accepts candidates, answers after 0..lat_max cycles.
    int  rdy_mode = 0, lat_max = 0, junk_en = 0, stall_left = 0;
    int  ev_cidx = 0, ord_bad = 0, fix_bad = 0, stab_bad = 0;
    int  dly = 0, cap_p = 0, cap_i = 0;
    bit  pending = 0, resp_now = 0, prev_stall = 0, rst_s = 0;
    logic [3:0] px, py, pfx, pfy;

    always @(posedge CLK) begin
        rst_s = RST;
        if (rst_s) begin
            pending    = 0;
            resp_now   = 0;
            prev_stall = 0;
        end else begin
            if (resp_now) begin
                pending  = 0;
                resp_now = 0;
            end
            if (prev_stall && !(ev.cand_valid && ev.cand_x == px && ev.cand_y == py &&
                                ev.fix_x == pfx && ev.fix_y == pfy))
                stab_bad++;
            prev_stall = ev.cand_valid && !ev.cand_ready;
            px  = ev.cand_x;
            py  = ev.cand_y;
            pfx = ev.fix_x;
            pfy = ev.fix_y;
            if (ev.cand_valid && ev.cand_ready) begin
                if (pending) ord_bad++;
                cap_p = ev_cidx / (G*G);
                cap_i = int'(ev.cand_y) * G + int'(ev.cand_x);
                if (cap_p >= m_passes || cap_i != ev_cidx % (G*G)) ord_bad++;
                else if (int'(ev.fix_x) != mfx[cap_p] || int'(ev.fix_y) != mfy[cap_p]) fix_bad++;
                if (cap_p >= NP) cap_p = NP - 1;
                ev_cidx++;
                pending = 1;
                dly     = int'($urandom_range(0, lat_max));
            end
        end
        #1;
        ev.res_valid = 1'b0;
        ev.res_count = '0;
        if (!rst_s && pending) begin
            if (dly == 0) begin
                ev.res_valid = 1'b1;
                ev.res_count = 6'(sc[cap_p][cap_i]);
                resp_now     = 1;
            end else begin
                dly--;
            end
        end else if (junk_en != 0 && $urandom_range(0, 3) == 0) begin
            ev.res_valid = 1'b1;
            ev.res_count = 6'($urandom_range(0, 63));
        end
        case (rdy_mode)
            1:       ev.cand_ready = ($urandom_range(0, 2) != 0);
            2: begin
                ev.cand_ready = !(ev_cidx == 3 && stall_left > 0 && ev.cand_valid);
                if (!ev.cand_ready) stall_left--;
            end
            default: ev.cand_ready = 1'b1;
        endcase
    end

    task automatic run_opt(input string tag, input int rmode, input int lat, input int junk,
                           input bit poke, input bit chk_cyc);
        int cyc;
        model_run();
        rdy_mode   = rmode;
        lat_max    = lat;
        junk_en    = junk;
        stall_left = 3;
        ev_cidx    = 0;
        ord_bad    = 0;
        fix_bad    = 0;
        stab_bad   = 0;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        check_eq({tag, ":busy_after_start"}, int'(busy), 1);
        check_eq({tag, ":done_after_start"}, int'(done), 0);
        check_eq({tag, ":fix_first"}, int'({ev.fix_y, ev.fix_x}), mfy[0] * G + mfx[0]);
        cyc = 0;
        while (!done && cyc < 40000) begin
            if (poke && $urandom_range(0, 39) == 0) start = 1'b1;
            @(posedge CLK); #1;
            start = 1'b0;
            cyc++;
        end
        check_eq({tag, ":reached_done"}, int'(cyc < 40000), 1);
        if (chk_cyc) check_eq({tag, ":cycles"}, cyc, m_passes * (2 * G * G + 1));
        check_eq({tag, ":busy_in_done"}, int'(busy), 0);
        check_eq({tag, ":accepted"}, ev_cidx, m_passes * G * G);
        check_eq({tag, ":scan_order"}, ord_bad, 0);
        check_eq({tag, ":fix_per_pass"}, fix_bad, 0);
        check_eq({tag, ":stall_hold"}, stab_bad, 0);
        if (rmode == 2) check_eq({tag, ":stall_cycles_used"}, stall_left, 0);
        check_eq({tag, ":c1"}, int'({C1Y, C1X}), m_c1y * G + m_c1x);
        check_eq({tag, ":c2"}, int'({C2Y, C2X}), m_c2y * G + m_c2x);
    endtask

    task automatic reset_mid_wait();
        int k;
        model_run();
        rdy_mode = 0;
        lat_max  = 0;
        junk_en  = 0;
        ev_cidx  = 0;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (21) @(posedge CLK);
        #1;
        k = 0;
        while (!(busy && !ev.cand_valid) && k < 8) begin
            @(posedge CLK); #1;
            k++;
        end
        check_eq("rstw:found_wait", int'(k < 8), 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check_eq("rstw:busy", int'(busy), 0);
        check_eq("rstw:done", int'(done), 0);
        check_eq("rstw:cand_valid", int'(ev.cand_valid), 0);
        check_eq("rstw:c_all", int'({C1X, C1Y, C2X, C2Y}), 0);
        check_eq("rstw:cand_xy", int'({ev.cand_x, ev.cand_y}), 0);
        m_c1x = 0; m_c1y = 0; m_c2x = 0; m_c2y = 0;
        @(posedge CLK); #1;
        check_eq("rstw:stays_idle", int'(busy), 0);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst:cand_valid", int'(ev.cand_valid), 0);
        check_eq("rst:cand_xy", int'({ev.cand_x, ev.cand_y}), 0);
        check_eq("rst:fix", int'({ev.fix_x, ev.fix_y}), 0);
        check_eq("rst:busy", int'(busy), 0);
        check_eq("rst:done", int'(done), 0);
        check_eq("rst:c1", int'({C1X, C1Y}), 0);
        check_eq("rst:c2", int'({C2X, C2Y}), 0);
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_eq("idle:no_start_busy", int'(busy), 0);
        check_eq("idle:no_start_valid", int'(ev.cand_valid), 0);

        // Single peak at (5,7): converges after four passes.
        fill_peaks(7 * G + 5, 7 * G + 5, 1);
        run_opt("peak", 0, 0, 0, 1'b0, 1'b1);

        // Equal peaks at (2,2) and (9,4), restarted from DONE: later position wins.
        fill_peaks(2 * G + 2, 4 * G + 9, 3);
        run_opt("tie", 0, 0, 0, 1'b0, 1'b1);

        // Directed 3-cycle stall at (3,0) with junk strobes and stray start pulses.
        fill_rand();
        run_opt("stall", 2, 0, 1, 1'b1, 1'b0);

        // Random ready, random latency, junk strobes, stray start pulses.
        fill_rand();
        run_opt("rand", 1, 3, 1, 1'b1, 1'b0);

        reset_mid_wait();

        // Fresh start from IDLE with random scores and zero latency.
        fill_rand();
        run_opt("idle_rand", 0, 0, 0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
